pll_reset_sequencer: RTL and testbench



---
 rtl/pll_reset_sequencer.sv | 161 ++++++++++++++++
 tb/tb_pll_reset_sequencer.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/pll_reset_sequencer.sv
// pll_reset_sequencer: lock supervisor and staggered reset sequencer for an
// ECP5 EHXPLLL. Runs on the free-running board reference clock. It pulses the
// PLL reset, waits for lock with timeout and retry, requires a continuously
// stable lock window, then releases per-domain resets one at a time. Lock loss
// or a relock request re-asserts every domain reset and restarts the PLL.
//
// Ports:
//   clk              board reference clock, free-running
//   rst              asynchronous active-high reset
//   pll_locked       PLL LOCK, asynchronous to clk
//   force_relock     single-cycle request to restart the PLL
//   pll_rst          drives EHXPLLL RST
//   domain_rst       active-high per-domain resets, bit 0 released first
//   ready            all domains released and lock held
//   lock_loss_count  lock drops seen in RELEASE or RUN (saturating)
//   timeout_count    lock-wait timeouts (saturating)
module pll_reset_sequencer #(
  parameter int unsigned NUM_DOMAINS         = 4,
  parameter int unsigned PLL_RST_CYCLES      = 8,
  parameter int unsigned LOCK_TIMEOUT_CYCLES = 65536,
  parameter int unsigned LOCK_STABLE_CYCLES  = 1024,
  parameter int unsigned STAGGER_CYCLES      = 16,
  parameter int unsigned CNT_W               = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   pll_locked,
  input  logic                   force_relock,
  output logic                   pll_rst,
  output logic [NUM_DOMAINS-1:0] domain_rst,
  output logic                   ready,
  output logic [CNT_W-1:0]       lock_loss_count,
  output logic [CNT_W-1:0]       timeout_count
);

  localparam int unsigned MAX_A   = (PLL_RST_CYCLES > LOCK_TIMEOUT_CYCLES) ?
                                    PLL_RST_CYCLES : LOCK_TIMEOUT_CYCLES;
  localparam int unsigned MAX_B   = (LOCK_STABLE_CYCLES > STAGGER_CYCLES) ?
                                    LOCK_STABLE_CYCLES : STAGGER_CYCLES;
  localparam int unsigned MAX_CYC = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int unsigned CW      = $clog2(MAX_CYC + 1);
  localparam int unsigned IW      = (NUM_DOMAINS > 1) ? $clog2(NUM_DOMAINS) : 1;

  typedef enum logic [2:0] {
    S_PLL_RST,
    S_WAIT_LOCK,
    S_STABLE,
    S_RELEASE,
    S_RUN
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [IW-1:0] idx;
  logic          sync0;
  logic          lock_s;
  logic          lock_drop;
  logic          relock;

  // Two-flop synchronizer for the asynchronous PLL lock.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync0  <= 1'b0;
      lock_s <= 1'b0;
    end else begin
      sync0  <= pll_locked;
      lock_s <= sync0;
    end
  end

  // Lock loss only counts once domains are being released; relock is ignored
  // while the PLL is already being reset.
  assign lock_drop = ((state == S_RELEASE) || (state == S_RUN)) && !lock_s;
  assign relock    = force_relock && (state != S_PLL_RST);

  // Sequencer FSM with registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= S_PLL_RST;
      cnt             <= '0;
      idx             <= '0;
      pll_rst         <= 1'b1;
      domain_rst      <= '1;
      ready           <= 1'b0;
      lock_loss_count <= '0;
      timeout_count   <= '0;
    end else begin
      cnt <= cnt + CW'(1);
      if (lock_drop || relock) begin
        // Lock loss wins over a simultaneous relock request for counting.
        state      <= S_PLL_RST;
        cnt        <= '0;
        idx        <= '0;
        pll_rst    <= 1'b1;
        domain_rst <= '1;
        ready      <= 1'b0;
        if (lock_drop && (lock_loss_count != '1)) begin
          lock_loss_count <= lock_loss_count + CNT_W'(1);
        end
      end else begin
        case (state)
          S_PLL_RST: begin
            if (cnt == CW'(PLL_RST_CYCLES - 1)) begin
              state   <= S_WAIT_LOCK;
              cnt     <= '0;
              pll_rst <= 1'b0;
            end
          end
          S_WAIT_LOCK: begin
            if (lock_s) begin
              state <= S_STABLE;
              cnt   <= '0;
            end else if (cnt == CW'(LOCK_TIMEOUT_CYCLES - 1)) begin
              state      <= S_PLL_RST;
              cnt        <= '0;
              pll_rst    <= 1'b1;
              domain_rst <= '1;
              if (timeout_count != '1) begin
                timeout_count <= timeout_count + CNT_W'(1);
              end
            end
          end
          S_STABLE: begin
            if (!lock_s) begin
              state      <= S_WAIT_LOCK;
              cnt        <= '0;
              domain_rst <= '1;
            end else if (cnt == CW'(LOCK_STABLE_CYCLES - 1)) begin
              state <= S_RELEASE;
              cnt   <= '0;
              idx   <= '0;
            end
          end
          S_RELEASE: begin
            if (cnt == CW'(STAGGER_CYCLES - 1)) begin
              cnt        <= '0;
              idx        <= idx + IW'(1);
              domain_rst <= domain_rst & ~(NUM_DOMAINS'(1) << idx);
              if (idx == IW'(NUM_DOMAINS - 1)) begin
                state <= S_RUN;
                ready <= 1'b1;
              end
            end
          end
          S_RUN: begin
            cnt <= cnt;
          end
          default: begin
            state      <= S_PLL_RST;
            cnt        <= '0;
            idx        <= '0;
            pll_rst    <= 1'b1;
            domain_rst <= '1;
            ready      <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Testbench for pll_reset_sequencer with the reduced test-plan parameters.
module tb_pll_reset_sequencer;

  logic       clk;
  logic       rst;
  logic       pll_locked;
  logic       force_relock;
  logic       pll_rst;
  logic [2:0] domain_rst;
  logic       ready;
  logic [3:0] lock_loss_count;
  logic [3:0] timeout_count;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string      name;
    logic       pll;
    logic [2:0] dom;
    logic       rdy;
    logic [3:0] ll;
    logic [3:0] to;
  } exp_t;

  typedef struct {
    string      name;
    bit         locked;
    bit         frc;
    int         cycles;
    logic       pll;
    logic [2:0] dom;
    logic       rdy;
    logic [3:0] ll;
    logic [3:0] to;
  } vec_t;

  exp_t sb[$];
  vec_t tbl[$];

  pll_reset_sequencer #(
    .NUM_DOMAINS(3),
    .PLL_RST_CYCLES(4),
    .LOCK_TIMEOUT_CYCLES(50),
    .LOCK_STABLE_CYCLES(10),
    .STAGGER_CYCLES(5),
    .CNT_W(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .pll_locked(pll_locked),
    .force_relock(force_relock),
    .pll_rst(pll_rst),
    .domain_rst(domain_rst),
    .ready(ready),
    .lock_loss_count(lock_loss_count),
    .timeout_count(timeout_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic expect_out(input string name, input logic pll, input logic [2:0] dom,
                            input logic rdy, input logic [3:0] ll, input logic [3:0] to);
    exp_t e;
    e.name = name; e.pll = pll; e.dom = dom; e.rdy = rdy; e.ll = ll; e.to = to;
    sb.push_back(e);
  endtask

  task automatic check_out();
    exp_t e;
    e = sb.pop_front();
    checks++;
    if (pll_rst !== e.pll || domain_rst !== e.dom || ready !== e.rdy ||
        lock_loss_count !== e.ll || timeout_count !== e.to) begin
      errors++;
      $display("FAIL %s: got pll_rst=%0b domain_rst=%b ready=%0b lock_loss=%0d timeout=%0d, expected pll_rst=%0b domain_rst=%b ready=%0b lock_loss=%0d timeout=%0d",
               e.name, pll_rst, domain_rst, ready, lock_loss_count, timeout_count,
               e.pll, e.dom, e.rdy, e.ll, e.to);
    end
  endtask

  // Drive inputs, queue the expectation, advance, then compare.
  task automatic run_vec(input vec_t v);
    pll_locked   = v.locked;
    force_relock = v.frc;
    expect_out(v.name, v.pll, v.dom, v.rdy, v.ll, v.to);
    repeat (v.cycles) @(negedge clk);
    check_out();
  endtask

  task automatic add(input string name, input bit locked, input bit frc, input int cycles,
                     input logic pll, input logic [2:0] dom, input logic rdy,
                     input logic [3:0] ll, input logic [3:0] to);
    vec_t v;
    v.name = name; v.locked = locked; v.frc = frc; v.cycles = cycles;
    v.pll = pll; v.dom = dom; v.rdy = rdy; v.ll = ll; v.to = to;
    tbl.push_back(v);
  endtask

  task automatic wait_ready(input string name, input int budget);
    int n = 0;
    while (!ready && n < budget) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (ready !== 1'b1) begin
      errors++;
      $display("FAIL %s: ready=%0b after %0d cycles, expected 1", name, ready, n);
    end
  endtask

  initial begin
    vec_t v;
    int   n;

    // Bring-up: lock rises after edge 20, STABLE at 23, RELEASE at 33.
    add("bu_e1",   0, 0, 1,  1, 3'd7, 0, 0, 0);
    add("bu_e3",   0, 0, 2,  1, 3'd7, 0, 0, 0);
    add("bu_e4",   0, 0, 1,  0, 3'd7, 0, 0, 0);
    add("bu_e20",  0, 0, 16, 0, 3'd7, 0, 0, 0);
    add("bu_e37",  1, 0, 17, 0, 3'd7, 0, 0, 0);
    add("bu_d0",   1, 0, 1,  0, 3'd6, 0, 0, 0);
    add("bu_e42",  1, 0, 4,  0, 3'd6, 0, 0, 0);
    add("bu_d1",   1, 0, 1,  0, 3'd4, 0, 0, 0);
    add("bu_e47",  1, 0, 4,  0, 3'd4, 0, 0, 0);
    add("bu_d2",   1, 0, 1,  0, 3'd0, 1, 0, 0);
    add("bu_run",  1, 0, 10, 0, 3'd0, 1, 0, 0);
    // Lock loss in RUN: 3 cycles to full reset, 4-cycle pll_rst pulse.
    add("ll_e2",   0, 0, 2,  0, 3'd0, 1, 0, 0);
    add("ll_e3",   0, 0, 1,  1, 3'd7, 0, 1, 0);
    add("ll_pr3",  0, 0, 3,  1, 3'd7, 0, 1, 0);
    add("ll_pr4",  0, 0, 1,  0, 3'd7, 0, 1, 0);
    // Re-lock: full staggered release again.
    add("rl_17",   1, 0, 17, 0, 3'd7, 0, 1, 0);
    add("rl_d0",   1, 0, 1,  0, 3'd6, 0, 1, 0);
    add("rl_22",   1, 0, 4,  0, 3'd6, 0, 1, 0);
    add("rl_d1",   1, 0, 1,  0, 3'd4, 0, 1, 0);
    add("rl_27",   1, 0, 4,  0, 3'd4, 0, 1, 0);
    add("rl_d2",   1, 0, 1,  0, 3'd0, 1, 1, 0);
    add("rl_run",  1, 0, 5,  0, 3'd0, 1, 1, 0);
    // force_relock in RUN, second pulse during PLL_RST must be ignored.
    add("fr_hit",  1, 1, 1,  1, 3'd7, 0, 1, 0);
    add("fr_ign",  1, 1, 1,  1, 3'd7, 0, 1, 0);
    add("fr_pr3",  1, 0, 2,  1, 3'd7, 0, 1, 0);
    add("fr_pr4",  1, 0, 1,  0, 3'd7, 0, 1, 0);
    // Glitch mid-STABLE: window restarts, no early release, no loss count.
    add("gl_f8",   1, 0, 4,  0, 3'd7, 0, 1, 0);
    add("gl_f11",  0, 0, 3,  0, 3'd7, 0, 1, 0);
    add("gl_f20",  1, 0, 9,  0, 3'd7, 0, 1, 0);
    add("gl_f28",  1, 0, 8,  0, 3'd7, 0, 1, 0);
    add("gl_d0",   1, 0, 1,  0, 3'd6, 0, 1, 0);
    add("gl_run",  1, 0, 10, 0, 3'd0, 1, 1, 0);

    rst          = 1'b1;
    pll_locked   = 1'b0;
    force_relock = 1'b0;
    #12;
    expect_out("reset_state", 1, 3'd7, 0, 0, 0);
    check_out();

    @(negedge clk);
    rst = 1'b0;
    foreach (tbl[i]) run_vec(tbl[i]);
    force_relock = 1'b0;

    // Repeated lock losses: counter saturates at 15.
    for (int i = 1; i <= 20; i++) begin
      pll_locked = 1'b0;
      repeat (3) @(negedge clk);
      expect_out($sformatf("sat%0d", i), 1, 3'd7, 0, 4'(((1 + i) > 15) ? 15 : (1 + i)), 0);
      check_out();
      pll_locked = 1'b1;
      wait_ready($sformatf("sat_ready%0d", i), 100);
    end

    // No lock for 300 cycles: 4-wide pulse every 54 cycles, 5 timeouts.
    pll_locked = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    expect_out("nl_reset", 1, 3'd7, 0, 0, 0);
    check_out();
    rst = 1'b0;
    for (int k = 1; k <= 300; k++) begin
      @(negedge clk);
      expect_out($sformatf("nl_k%0d", k), ((k % 54) < 4) ? 1'b1 : 1'b0, 3'd7, 0, 0, 4'(k / 54));
      check_out();
    end

    // Async reset mid-RELEASE after domain 0 is released.
    pll_locked = 1'b1;
    n = 0;
    while (domain_rst !== 3'd6 && n < 200) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (domain_rst !== 3'd6) begin
      errors++;
      $display("FAIL ar_release: domain_rst=%b after %0d cycles, expected 110", domain_rst, n);
    end
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    expect_out("ar_async", 1, 3'd7, 0, 0, 0);
    check_out();
    @(negedge clk);
    rst = 1'b0;
    v.name = "ar_e3"; v.locked = 1; v.frc = 0; v.cycles = 3;
    v.pll = 1; v.dom = 3'd7; v.rdy = 0; v.ll = 0; v.to = 0;
    run_vec(v);
    v.name = "ar_e4"; v.cycles = 1; v.pll = 0;
    run_vec(v);
    wait_ready("ar_ready", 100);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
